cpu6_pipe_regs: RTL and testbench

- Parametrised elastic pipeline register chain. It generalises the cpu6 single flops (load-enable, reset, plain) into DEPTH stages of DW-bit registers with a valid/ready handshake, bubble collapse and synchronous flush.
- Sits between cpu6 pipeline stages, for example fetch→decode and decode→execute. It replaces hand-instantiated load-enable flops and hand-built stall logic.

---
 rtl/cpu6_pipe_regs.sv | 147 ++++++++++++++
 tb/tb_cpu6_pipe_regs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : cpu6_pipe_regs
// Purpose  : Elastic pipeline register chain of DEPTH stages, each DW bits
//            wide, with valid/ready handshake, bubble collapse and a
//            synchronous flush. Placed between cpu6 pipeline stages in place
//            of hand-built load-enable flops and stall logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW     data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1); also the fill latency
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (clears all valid bits)
//   flush      in   synchronous kill of every held entry
//   in_valid   in   upstream presents in_data
//   in_ready   out  chain accepts in_data this cycle
//   in_data    in   upstream payload [DW-1:0]
//   out_valid  out  last stage holds a valid entry
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload of the last stage [DW-1:0]
//   occ        out  number of valid stages [$clog2(DEPTH+1)-1:0]
// Build option
//   CPU6_PIPE_DATA_RST_EN  when defined, data registers are cleared by rst;
//                          otherwise they have no reset.
// ============================================================================
module cpu6_pipe_regs #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int c_OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  src_valid;
    logic [DEPTH-1:0]  load;
    logic [DW-1:0]     stage_data [DEPTH];
    logic [DW-1:0]     src_data   [DEPTH];
    logic [c_OCC_W-1:0] occ_sum;

    // ------------------------------------------------------------------
    // Advance chain: a stage moves when it is empty or its successor
    // moves. Evaluated from the output side back so that an empty stage
    // anywhere in the chain lets everything upstream of it advance
    // (bubble collapse). This is the DEPTH-deep out_ready -> in_ready path.
    // ------------------------------------------------------------------
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = ~valid_q[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~valid_q[i] | adv[i+1];
        end
    end

    // Input is refused during flush so nothing new survives the kill.
    assign in_ready = adv[0] & ~flush;

    // ------------------------------------------------------------------
    // Per-stage source selection and data registers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [DW-1:0] data_q;
        logic [DW-1:0] data_d;

        if (gi == 0) begin : g_head
            assign src_valid[gi] = in_valid & in_ready;
            assign src_data[gi]  = in_data;
        end else begin : g_body
            assign src_valid[gi] = valid_q[gi-1];
            assign src_data[gi]  = stage_data[gi-1];
        end

        // Data only captures real entries; an advancing bubble leaves the
        // old payload in place, which is harmless because valid is clear.
        assign load[gi]   = adv[gi] & src_valid[gi];
        assign data_d     = load[gi] ? src_data[gi] : data_q;

`ifdef CPU6_PIPE_DATA_RST_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end
`else
        always_ff @(posedge clk) begin
            data_q <= data_d;
        end
`endif

        assign stage_data[gi] = data_q;
    end

    // ------------------------------------------------------------------
    // Valid bits: flush dominates, then advance, otherwise hold.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (adv[i]) begin
                valid_d[i] = src_valid[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: popcount of the valid flops.
    // ------------------------------------------------------------------
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + c_OCC_W'(valid_q[i]);
        end
    end

    assign occ       = occ_sum;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_cpu6_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu6_pipe_regs
// Purpose  : Self-checking bench for cpu6_pipe_regs. A DEPTH=3/DW=32 and a
//            DEPTH=1/DW=8 instance share clock and reset. Accepted inputs are
//            queued as expected outputs; monitors pop and compare on every
//            output transfer and check occupancy/ready against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu6_pipe_regs;

    logic clk;
    logic rst;

    // DEPTH=3, DW=32 instance signals
    logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
    logic [31:0] in_data3, out_data3;
    logic [1:0]  occ3;

    // DEPTH=1, DW=8 instance signals
    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0]  in_data1, out_data1;
    logic        occ1;

    int n_cmp = 0;
    int n_err = 0;
    int n_out1 = 0;

    logic [31:0] q3[$];
    logic [7:0]  q1[$];

    cpu6_pipe_regs #(.DW(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .occ(occ3)
    );

    cpu6_pipe_regs #(.DW(8), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occ(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitors: sample mid-cycle (negedge). The reference is a FIFO of
    // accepted words; a chain with free room or a consuming sink always
    // accepts, so ready = !flush & (count < DEPTH | out_ready).
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] e3;
        if (rst) begin
            q3.delete();
        end else begin
            chk("occ3", 32'(occ3), 32'(q3.size()));
            chk("in_ready3", 32'(in_ready3),
                32'(!flush3 && (q3.size() < 3 || out_ready3)));
            if (q3.size() == 0) chk("ovalid3_empty", 32'(out_valid3), 32'd0);
            if (out_valid3 && out_ready3) begin
                if (q3.size() == 0) begin
                    chk("underflow3", 32'd1, 32'd0);
                end else begin
                    e3 = q3.pop_front();
                    chk("data3", out_data3, e3);
                end
            end
            if (flush3) q3.delete();
            else if (in_valid3 && in_ready3) q3.push_back(in_data3);
        end
    end

    always @(negedge clk) begin
        logic [7:0] e1;
        if (rst) begin
            q1.delete();
        end else begin
            chk("occ1", 32'(occ1), 32'(q1.size()));
            chk("ovalid1", 32'(out_valid1), 32'(q1.size() == 1));
            chk("in_ready1", 32'(in_ready1),
                32'(!flush1 && (q1.size() == 0 || out_ready1)));
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("underflow1", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("data1", 32'(out_data1), 32'(e1));
                    n_out1++;
                end
            end
            if (flush1) q1.delete();
            else if (in_valid1 && in_ready1) q1.push_back(in_data1);
        end
    end

    // Push three words back-to-back with the sink stalled.
    task automatic fill3(input logic [31:0] base);
        out_ready3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1;
            in_data3  = base + 32'(i);
            step();
        end
        in_valid3 = 1'b0;
    endtask

    initial begin
        logic sent;
        int   k;

        rst = 1'b1;
        flush3 = 0; in_valid3 = 0; out_ready3 = 0; in_data3 = '0;
        flush1 = 0; in_valid1 = 0; out_ready1 = 0; in_data1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset state
        chk("rst_ovalid3", 32'(out_valid3), 32'd0);
        chk("rst_occ3", 32'(occ3), 32'd0);
        chk("rst_in_ready3", 32'(in_ready3), 32'd1);
        chk("rst_ovalid1", 32'(out_valid1), 32'd0);
        chk("rst_in_ready1", 32'(in_ready1), 32'd1);
`ifdef CPU6_PIPE_DATA_RST_EN
        chk("rst_odata3", out_data3, 32'd0);
`endif
        step();

        // Stream: first output two edges after first accept
        out_ready3 = 1'b1;
        in_valid3 = 1'b1; in_data3 = 32'h11;
        step();
        chk("stream_ov_e1", 32'(out_valid3), 32'd0);
        chk("stream_rdy_e1", 32'(in_ready3), 32'd1);
        in_data3 = 32'h22;
        step();
        chk("stream_ov_e2", 32'(out_valid3), 32'd0);
        in_data3 = 32'h33;
        step();
        in_valid3 = 1'b0;
        chk("stream_ov_e3", 32'(out_valid3), 32'd1);
        chk("stream_d_e3", out_data3, 32'h11);
        step();
        chk("stream_d_e4", out_data3, 32'h22);
        step();
        chk("stream_d_e5", out_data3, 32'h33);
        step();
        chk("stream_ov_e6", 32'(out_valid3), 32'd0);

        // Back-pressure: 4th word waits for the first pop
        fill3(32'hB0);
        in_valid3 = 1'b1; in_data3 = 32'hB3;
        #1;
        chk("bp_occ_full", 32'(occ3), 32'd3);
        chk("bp_rdy_full", 32'(in_ready3), 32'd0);
        out_ready3 = 1'b1;
        #1;
        chk("bp_rdy_pop", 32'(in_ready3), 32'd1);
        step();
        in_valid3 = 1'b0;
        chk("bp_occ_after", 32'(occ3), 32'd3);
        repeat (4) step();
        chk("bp_drained", 32'(occ3), 32'd0);

        // Bubble collapse with stalled output
        out_ready3 = 1'b0;
        in_valid3 = 1'b1; in_data3 = 32'hAA;
        step();
        in_valid3 = 1'b0;
        step();
        step();
        chk("bub_occ1", 32'(occ3), 32'd1);
        chk("bub_ov", 32'(out_valid3), 32'd1);
        chk("bub_d_aa", out_data3, 32'hAA);
        in_valid3 = 1'b1; in_data3 = 32'hBB;
        #1;
        chk("bub_rdy", 32'(in_ready3), 32'd1);
        step();
        in_valid3 = 1'b0;
        step();
        chk("bub_occ2", 32'(occ3), 32'd2);
        chk("bub_d_hold", out_data3, 32'hAA);
        out_ready3 = 1'b1;
        step();
        chk("bub_bb_next", out_data3, 32'hBB);
        chk("bub_bb_ov", 32'(out_valid3), 32'd1);
        step();
        chk("bub_empty", 32'(out_valid3), 32'd0);

        // Flush with a full chain: head delivered, rest discarded
        fill3(32'hF0);
        out_ready3 = 1'b1; flush3 = 1'b1;
        in_valid3 = 1'b1; in_data3 = 32'hC5;
        #1;
        chk("fl_rdy", 32'(in_ready3), 32'd0);
        step();
        flush3 = 1'b0;
        chk("fl_occ", 32'(occ3), 32'd0);
        chk("fl_ov", 32'(out_valid3), 32'd0);
        step();
        in_valid3 = 1'b0;
        chk("fl_lat_e1", 32'(out_valid3), 32'd0);
        step();
        chk("fl_lat_e2", 32'(out_valid3), 32'd0);
        step();
        chk("fl_lat_e3", 32'(out_valid3), 32'd1);
        chk("fl_lat_d", out_data3, 32'hC5);
        step();

        // Asynchronous reset while stalled and full
        fill3(32'hD0);
        #2 rst = 1'b1;
        #1;
        chk("ar_ov", 32'(out_valid3), 32'd0);
        chk("ar_occ", 32'(occ3), 32'd0);
`ifdef CPU6_PIPE_DATA_RST_EN
        chk("ar_data", out_data3, 32'd0);
`endif
        step();
        rst = 1'b0;
        #1;
        chk("ar_rdy", 32'(in_ready3), 32'd1);
        step();

        // Randomised traffic with occasional flush
        sent = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            out_ready3 = ($urandom % 3) != 0;
            flush3     = ($urandom % 25) == 0;
            if (sent || !in_valid3) begin
                in_valid3 = ($urandom % 4) != 0;
                in_data3  = $urandom;
            end
            #1;
            sent = in_valid3 & in_ready3;
            step();
        end
        flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b1;
        repeat (5) step();
        chk("rand_drain_occ", 32'(occ3), 32'd0);
        chk("rand_drain_q", 32'(q3.size()), 32'd0);

        // DEPTH=1: alternating out_ready, 16 words 0x00..0x0F
        k = 0;
        out_ready1 = 1'b0;
        for (int n = 0; n < 200 && k < 16; n++) begin
            out_ready1 = ~out_ready1;
            in_valid1  = 1'b1;
            in_data1   = 8'(k);
            #1;
            chk("d1_rdy", 32'(in_ready1), 32'(!out_valid1 || out_ready1));
            if (in_ready1) k++;
            step();
        end
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) step();
        chk("d1_accepted", 32'(k), 32'd16);
        chk("d1_delivered", 32'(n_out1), 32'd16);
        chk("d1_q_empty", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
